// File: rtl/spu_div_pkg.sv
// Shared constants and tag layout for the SPU divider arbiter, its FIFOs and the divider instance.
package spu_div_pkg;

   localparam int DEF_DIV_LAT   = 9;
   localparam int DEF_RES_DEPTH = 16;

   // Tag word travelling alongside each divide: {id, dz}
   localparam int TAG_DZ_BIT = 0;
   localparam int TAG_ID_LSB = 1;

   function automatic int calc_id_w(input int num_req);
      return (num_req > 1) ? $clog2(num_req) : 1;
   endfunction

   function automatic int calc_tag_w(input int num_req);
      return calc_id_w(num_req) + 1;
   endfunction

endpackage

// File: rtl/spu_div_fifo.sv
// Show-ahead synchronous FIFO; the head word is visible on o_dout whenever o_empty is low.
module spu_div_fifo
   import spu_div_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic             core_clk,
   input  logic             rst_n,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_din,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_dout,
   output logic             o_full,
   output logic             o_empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW:0]      r_wr_ptr;
   logic [AW:0]      r_rd_ptr;
   logic             w_do_push;
   logic             w_do_pop;

   assign o_empty   = (r_wr_ptr == r_rd_ptr);
   assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign w_do_pop  = i_pop & ~o_empty;
   // A pop frees the head slot in the same edge, so push-on-full is legal when popping.
   assign w_do_push = i_push & (~o_full | w_do_pop);

   always_ff @(posedge core_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge core_clk) begin
      if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_din;
   end

   assign o_dout = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: rtl/spu_div_arbiter.sv
// Round-robin front end sharing one pipelined signed divider among NUM_REQ requesters,
// with in-order tag tracking and a credit-protected result FIFO.
module spu_div_arbiter
   import spu_div_pkg::*;
#(
   parameter int NUM_REQ      = 4,
   parameter int DIVIDEND_DW  = 1,
   parameter int DIVISOR_DW   = 10,
   parameter int PRECISION_DW = 14,
   parameter int DIV_LAT      = DEF_DIV_LAT,
   parameter int RES_DEPTH    = DEF_RES_DEPTH,
   localparam int TOTAL_DW    = DIVIDEND_DW + PRECISION_DW,
   localparam int ID_W        = calc_id_w(NUM_REQ)
) (
   input  logic                            core_clk,
   input  logic                            rst_n,
   input  logic [NUM_REQ-1:0]              req_vld,
   output logic [NUM_REQ-1:0]              req_rdy,
   input  logic [NUM_REQ*DIVIDEND_DW-1:0]  req_dividend,
   input  logic [NUM_REQ*DIVISOR_DW-1:0]   req_divisor,
   output logic                            div_vld,
   output logic [DIVIDEND_DW-1:0]          div_data0,
   output logic [DIVISOR_DW-1:0]           div_data1,
   input  logic [TOTAL_DW-1:0]             div_data_out,
   input  logic                            div_ack,
   output logic                            rsp_vld,
   input  logic                            rsp_rdy,
   output logic [TOTAL_DW-1:0]             rsp_data,
   output logic [ID_W-1:0]                 rsp_id,
   output logic                            rsp_dz,
   output logic                            busy,
   output logic                            err
);

   localparam int TAG_W = calc_tag_w(NUM_REQ);
   localparam int RES_W = TOTAL_DW + TAG_W;
   localparam int CNT_W = $clog2(RES_DEPTH + 1);

   if (DIV_LAT < 1 || NUM_REQ < 2 || RES_DEPTH < 2 || (RES_DEPTH & (RES_DEPTH - 1)) != 0) begin : g_bad_cfg
      $error("spu_div_arbiter: illegal parameter combination");
   end

   logic [DIVIDEND_DW-1:0] w_dividend [NUM_REQ];
   logic [DIVISOR_DW-1:0]  w_divisor  [NUM_REQ];

   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign w_dividend[gi] = req_dividend[gi*DIVIDEND_DW +: DIVIDEND_DW];
      assign w_divisor[gi]  = req_divisor[gi*DIVISOR_DW +: DIVISOR_DW];
   end

   logic [ID_W-1:0]        r_rr_ptr;
   logic [CNT_W-1:0]       r_outstanding;
   logic                   r_div_vld;
   logic [DIVIDEND_DW-1:0] r_div_data0;
   logic [DIVISOR_DW-1:0]  r_div_data1;
   logic                   r_err;

   logic [NUM_REQ-1:0] w_grant;
   logic [ID_W-1:0]    w_win_id;
   logic [ID_W-1:0]    w_scan_idx;
   logic               w_found;
   logic               w_credit;
   logic               w_accept;
   logic               w_pop;
   logic               w_win_dz;
   logic [TAG_W-1:0]   w_tag_head;
   logic               w_tag_full;
   logic               w_tag_empty;
   logic               w_ret;
   logic [RES_W-1:0]   w_res_head;
   logic               w_res_full;
   logic               w_res_empty;

   // Scan upward from the round-robin pointer, wrapping at NUM_REQ.
   always_comb begin
      w_grant    = '0;
      w_win_id   = '0;
      w_found    = 1'b0;
      w_scan_idx = r_rr_ptr;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!w_found && req_vld[w_scan_idx]) begin
            w_found             = 1'b1;
            w_grant[w_scan_idx] = 1'b1;
            w_win_id            = w_scan_idx;
         end
         w_scan_idx = (w_scan_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_scan_idx + 1'b1;
      end
   end

   // Credit uses the registered count only; FIFO fullness can never bind before it does.
   assign w_credit = (r_outstanding < CNT_W'(RES_DEPTH)) & ~w_tag_full & ~w_res_full;
   assign req_rdy  = w_credit ? w_grant : '0;
   assign w_accept = |req_rdy;
   assign w_pop    = rsp_vld & rsp_rdy;
   assign w_win_dz = (w_divisor[w_win_id] == '0);
   assign w_ret    = div_ack & ~w_tag_empty;

   always_ff @(posedge core_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rr_ptr      <= '0;
         r_outstanding <= '0;
         r_div_vld     <= 1'b0;
         r_div_data0   <= '0;
         r_div_data1   <= '0;
         r_err         <= 1'b0;
      end else begin
         r_div_vld <= w_accept;
         if (w_accept) begin
            r_div_data0 <= w_dividend[w_win_id];
            r_div_data1 <= w_divisor[w_win_id];
            r_rr_ptr    <= (w_win_id == ID_W'(NUM_REQ - 1)) ? '0 : w_win_id + 1'b1;
         end
         unique case ({w_accept, w_pop})
            2'b10:   r_outstanding <= r_outstanding + 1'b1;
            2'b01:   r_outstanding <= r_outstanding - 1'b1;
            default: r_outstanding <= r_outstanding;
         endcase
         if (div_ack && w_tag_empty) r_err <= 1'b1;
      end
   end

   spu_div_fifo #(.WIDTH(TAG_W), .DEPTH(RES_DEPTH)) u_tag_fifo (
      .core_clk (core_clk),
      .rst_n    (rst_n),
      .i_push   (w_accept),
      .i_din    ({w_win_id, w_win_dz}),
      .i_pop    (w_ret),
      .o_dout   (w_tag_head),
      .o_full   (w_tag_full),
      .o_empty  (w_tag_empty)
   );

   spu_div_fifo #(.WIDTH(RES_W), .DEPTH(RES_DEPTH)) u_res_fifo (
      .core_clk (core_clk),
      .rst_n    (rst_n),
      .i_push   (w_ret),
      .i_din    ({div_data_out, w_tag_head}),
      .i_pop    (w_pop),
      .o_dout   (w_res_head),
      .o_full   (w_res_full),
      .o_empty  (w_res_empty)
   );

   assign div_vld   = r_div_vld;
   assign div_data0 = r_div_data0;
   assign div_data1 = r_div_data1;
   assign rsp_vld   = ~w_res_empty;
   assign rsp_data  = w_res_head[TAG_W +: TOTAL_DW];
   assign rsp_id    = w_res_head[TAG_ID_LSB +: ID_W];
   assign rsp_dz    = w_res_head[TAG_DZ_BIT];
   assign busy      = (r_outstanding != '0);
   assign err       = r_err;

endmodule

// File: doc/spu_div_arbiter.md
# spu_div_arbiter

Shares one pipelined signed divider (`spu_divider_sign`, one issue per cycle, fixed latency, no back-pressure) among NUM_REQ requesters in the SPU. It does three things:
- Round-robin arbitrates the requests and registers the winner into the divider.
- Tracks requester ID and a divide-by-zero flag through the pipeline, in order.
- Buffers results in a FIFO and returns them on a single valid/ready response port. Credit control guarantees that buffer can never overflow.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters (≥2).
- DIVIDEND_DW, 1, signed dividend width.
- DIVISOR_DW, 10, unsigned divisor width.
- PRECISION_DW, 14, fractional extension bits; TOTAL_DW = DIVIDEND_DW+PRECISION_DW.
- DIV_LAT, 9, divider latency; must equal popcount(divider STAGE_LIST)+1.
- RES_DEPTH, 16, result FIFO depth, power of two. Also the maximum number of outstanding requests.

Ports (ID_W = clog2(NUM_REQ)):
- core_clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- req_vld  in  NUM_REQ  per-requester request valid.
- req_rdy  out  NUM_REQ  one-hot grant, combinational.
- req_dividend  in  NUM_REQ*DIVIDEND_DW  packed, requester i at slice i.
- req_divisor  in  NUM_REQ*DIVISOR_DW  packed.
- div_vld  out  1  to divider.
- div_data0  out  DIVIDEND_DW  to divider.
- div_data1  out  DIVISOR_DW  to divider.
- div_data_out  in  TOTAL_DW  from divider.
- div_ack  in  1  from divider.
- rsp_vld  out  1  result FIFO not empty.
- rsp_rdy  in  1  consumer accept.
- rsp_data  out  TOTAL_DW  signed quotient.
- rsp_id  out  ID_W  originating requester.
- rsp_dz  out  1  divisor was zero.
- busy  out  1  outstanding≠0.
- err  out  1  sticky; set by div_ack while tag FIFO empty.

## Operation
- **Credit counter** `outstanding` (0..RES_DEPTH):
  - +1 on any accept, −1 on rsp_vld&rsp_rdy; both in the same cycle leave it unchanged.
  - Grant is allowed only when outstanding < RES_DEPTH, using the current registered value. A response pop in the same cycle does not enable a grant.
- **Arbiter:**
  - Round-robin pointer `rr_ptr`. Grant goes to the first i with req_vld[i]=1, searching from rr_ptr upward with wrap-around.
  - req_rdy = grant when credit is available, else all zeros.
  - On accept, rr_ptr ← winner+1 mod NUM_REQ. rr_ptr does not move when idle or stalled.
- **Issue register:**
  - On accept, div_data0/div_data1 capture the winner's operands and div_vld ← 1. Otherwise div_vld ← 0 and the data registers hold.
  - Tag FIFO (depth RES_DEPTH) pushes {id, divisor==0} on accept.
- **Return path:**
  - On div_ack, pop the tag FIFO and push {div_data_out, tag} into the result FIFO.
  - A push while full cannot occur; credit control guarantees it.
  - rsp_* shows the result FIFO head (show-ahead). Responses are in global issue order.
- **Divide-by-zero:** quotient is passed through unchanged (the divider yields all ones); only rsp_dz flags it.
- **err:** set on div_ack with tag FIFO empty (that response is dropped). Cleared only by reset.

## Timing
- **Reset values:** every output is 0. Both FIFOs empty, outstanding=0, rr_ptr=0.
- **Reset mid-operation:** all in-flight work is discarded. The divider shares rst_n, so no stale div_ack follows.
- **Latency:** accept at edge E → div_vld high after E → div_ack high after E+DIV_LAT → rsp_vld high after E+DIV_LAT+1. Minimum request-to-response is DIV_LAT+1 cycles (10 at default).
- **Throughput:** 1 accept/cycle sustained while rsp_rdy=1.
- **Back-pressure:** with rsp_rdy=0, exactly RES_DEPTH accepts occur, then req_rdy=0 until a pop.
- **Fairness:** with all requesters continuously valid, grant order is 0,1,2,3,0,…
- **Simultaneous push and pop on a full result FIFO:** both occur.

## Structure
- Shared package `spu_div_pkg` holds:
  - ID_W derivation.
  - Tag field layout {id, dz}.
  - Default DIV_LAT/RES_DEPTH constants, shared with the divider instantiation.
- Sub-module `spu_div_fifo`: synchronous, show-ahead, parameterized width/depth, with full/empty. Instantiated twice: tag FIFO and result FIFO.
- The arbiter, credit counter and issue register live in the top module.

## Test plan
Bench config: DIVIDEND_DW=8, DIVISOR_DW=8, PRECISION_DW=4 (TOTAL_DW=12), DIV_LAT matched to the divider instance.
- **Single request:** req 0 sends 100/7 → rsp_data=12'd228, rsp_id=0, rsp_dz=0, exactly DIV_LAT+1 cycles after accept.
- **Signed:** req 2 sends 8'h9C (−100)/7 → rsp_data=12'hF1C, rsp_id=2.
- **Zero divisor:** req 1 sends 5/0 → rsp_dz=1, rsp_data=12'hFFF, err stays 0.
- **Fairness:** all 4 requesters valid for 8 cycles → grants 0,1,2,3,0,1,2,3; responses return in the same ID order.
- **Back-pressure:** rsp_rdy=0 with continuous requests → exactly 16 accepts, then req_rdy=0. Release rsp_rdy → one accept per pop, no loss or duplication, outstanding never exceeds 16.
- **Reset mid-burst:** assert rst_n=0 with 5 requests in flight → all outputs 0, no rsp_vld after release; a new request completes normally.
